// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Radix-4 Booth windows {b[2i+1], b[2i], b[2i-1]}
    localparam logic [2:0] BOOTH_Z0  = 3'b000;
    localparam logic [2:0] BOOTH_P1A = 3'b001;
    localparam logic [2:0] BOOTH_P1B = 3'b010;
    localparam logic [2:0] BOOTH_P2  = 3'b011;
    localparam logic [2:0] BOOTH_M2  = 3'b100;
    localparam logic [2:0] BOOTH_M1A = 3'b101;
    localparam logic [2:0] BOOTH_M1B = 3'b110;
    localparam logic [2:0] BOOTH_Z1  = 3'b111;

endpackage

// File: rtl/muldiv_control_booth4_decode.sv
// Radix-4 Booth window decoder: selects +-M / +-2M / 0 for one step.
module booth4_decode
    import muldiv_pkg::*;
(
    input  logic [2:0] booth_bits,
    output logic       add,
    output logic       sub,
    output logic       shift_multiplicand
);

    always_comb begin
        add                = 1'b0;
        sub                = 1'b0;
        shift_multiplicand = 1'b0;
        case (booth_bits)
            BOOTH_P1A, BOOTH_P1B: add = 1'b1;
            BOOTH_P2: begin
                add                = 1'b1;
                shift_multiplicand = 1'b1;
            end
            BOOTH_M2: begin
                sub                = 1'b1;
                shift_multiplicand = 1'b1;
            end
            BOOTH_M1A, BOOTH_M1B: sub = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_control.sv
// Sequencer for Booth radix-4 multiply and non-restoring divide.
// Emits per-cycle datapath strobes plus a start/ready/done handshake.
module muldiv_control
    import muldiv_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int COUNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               mode,
    input  logic               div_zero,
    input  logic [2:0]         booth_bits,
    input  logic               rem_sign,
    output logic               load,
    output logic               add,
    output logic               sub,
    output logic               shift_multiplicand,
    output logic               shift_product,
    output logic               quot_bit,
    output logic               busy,
    output logic               ready,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] count
);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("muldiv_control: WIDTH must be even and >= 4");
    end

    localparam logic [COUNT_W-1:0] MUL_LAST = COUNT_W'(WIDTH / 2 - 1);
    localparam logic [COUNT_W-1:0] DIV_LAST = COUNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic               mode_q;
    logic               dz_q;
    logic               err_q;
    logic [COUNT_W-1:0] count_q;
    logic               at_last;
    logic               b_add;
    logic               b_sub;
    logic               b_sm;

    assign at_last = count_q == ((mode_q == MODE_DIV) ? DIV_LAST : MUL_LAST);

    booth4_decode u_booth (
        .booth_bits         (booth_bits),
        .add                (b_add),
        .sub                (b_sub),
        .shift_multiplicand (b_sm)
    );

    always_comb begin
        state_d            = state_q;
        load               = 1'b0;
        add                = 1'b0;
        sub                = 1'b0;
        shift_multiplicand = 1'b0;
        shift_product      = 1'b0;
        quot_bit           = 1'b0;
        done               = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = (mode_q == MODE_DIV && dz_q) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                shift_product = 1'b1;
                if (mode_q == MODE_MUL) begin
                    add                = b_add;
                    sub                = b_sub;
                    shift_multiplicand = b_sm;
                end else begin
                    add      = rem_sign;
                    sub      = !rem_sign;
                    quot_bit = !rem_sign;
                end
                if (at_last)
                    state_d = (mode_q == MODE_MUL) ? S_DONE : S_FIX;
            end
            S_FIX: begin
                // Restore a negative final remainder
                add     = rem_sign;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = state_q != S_IDLE;
    assign ready = state_q == S_IDLE;
    assign err   = done & err_q;
    assign count = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_MUL;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                mode_q  <= mode;
                dz_q    <= div_zero & (mode == MODE_DIV);
                err_q   <= 1'b0;
                count_q <= '0;
            end
            if (state_q == S_LOAD)
                err_q <= (mode_q == MODE_DIV) && dz_q;
            // Hold at the terminal step instead of wrapping
            if (state_q == S_RUN && !at_last)
                count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_control.sv
// Scoreboard bench: WIDTH=32 and WIDTH=8 sequencers against a cycle-trace model.
module tb_muldiv_control;

    typedef struct packed {
        logic       load;
        logic       add;
        logic       sub;
        logic       sm;
        logic       sp;
        logic       qb;
        logic       busy;
        logic       ready;
        logic       done;
        logic       err;
        logic [5:0] count;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st0, md0, dz0, rs0, st1, md1, dz1, rs1;
    logic [2:0] bb0, bb1;
    logic       ld0, ad0, sb0, sm0, sp0, qb0, by0, rd0, dn0, er0;
    logic       ld1, ad1, sb1, sm1, sp1, qb1, by1, rd1, dn1, er1;
    logic [5:0] cnt0;
    logic [3:0] cnt1;
    rec_t       act0, act1;

    muldiv_control #(.WIDTH(32)) dut32 (
        .clock(clk), .reset_n(rst_n), .start(st0), .mode(md0),
        .div_zero(dz0), .booth_bits(bb0), .rem_sign(rs0),
        .load(ld0), .add(ad0), .sub(sb0), .shift_multiplicand(sm0),
        .shift_product(sp0), .quot_bit(qb0), .busy(by0), .ready(rd0),
        .done(dn0), .err(er0), .count(cnt0)
    );

    muldiv_control #(.WIDTH(8)) dut8 (
        .clock(clk), .reset_n(rst_n), .start(st1), .mode(md1),
        .div_zero(dz1), .booth_bits(bb1), .rem_sign(rs1),
        .load(ld1), .add(ad1), .sub(sb1), .shift_multiplicand(sm1),
        .shift_product(sp1), .quot_bit(qb1), .busy(by1), .ready(rd1),
        .done(dn1), .err(er1), .count(cnt1)
    );

    assign act0 = {ld0, ad0, sb0, sm0, sp0, qb0, by0, rd0, dn0, er0, cnt0};
    assign act1 = {ld1, ad1, sb1, sm1, sp1, qb1, by1, rd1, dn1, er1,
                   2'b00, cnt1};

    rec_t q0[$];
    rec_t q1[$];
    int   last_cnt[2];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic rec_t idle_rec(input int c);
        rec_t r;
        r       = '0;
        r.ready = 1'b1;
        r.count = 6'(c);
        return r;
    endfunction

    task automatic check(input string nm, input rec_t e, input rec_t a);
        n_cmp++;
        if (e !== a) begin
            n_bad++;
            $display("FAIL %s t=%0t ld/add/sub/sm/sp/qb/busy/rdy/done/err got %b cnt=%0d, expected %b cnt=%0d",
                     nm, $time, a[15:6], a.count, e[15:6], e.count);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) check("w32_trace", q0.pop_front(), act0);
        else               check("w32_idle", idle_rec(last_cnt[0]), act0);
    end

    always @(negedge clk) begin
        if (q1.size() > 0) check("w8_trace", q1.pop_front(), act1);
        else               check("w8_idle", idle_rec(last_cnt[1]), act1);
    end

    task automatic drive(input int u, input logic s, input logic m,
                         input logic z, input logic [2:0] b, input logic r);
        if (u == 0) begin
            st0 = s; md0 = m; dz0 = z; bb0 = b; rs0 = r;
        end else begin
            st1 = s; md1 = m; dz1 = z; bb1 = b; rs1 = r;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 random, 1 booth 011 always, 2 rem_sign alternating, 3 booth sweep
    task automatic do_op(input int u, input bit m, input bit z, input int kind,
                         input int base, input bit hold, input int abort_at);
        int         w, n, steps, s, d;
        bit         dz_op, in_run;
        logic [2:0] b;
        logic       rr;
        rec_t       r;
        rec_t       tr[$];
        logic [2:0] bv[$];
        logic       rv[$];
        w     = (u == 0) ? 32 : 8;
        dz_op = m && z;
        steps = m ? w : w / 2;
        n     = dz_op ? 3 : (m ? w + 4 : w / 2 + 3);
        for (int k = 0; k < n; k++) begin
            b      = 3'($urandom);
            rr     = 1'($urandom);
            s      = k - 2;
            in_run = !dz_op && s >= 0 && s < steps;
            if (kind == 1) b = 3'b011;
            if (kind == 2 && in_run) rr = (s % 2) == 1;
            if (kind == 3 && in_run) b = 3'((base + s) % 8);
            r       = '0;
            r.busy  = k > 0;
            r.ready = k == 0;
            if (k == 0) begin
                r.count = 6'(last_cnt[u]);
            end else if (k == 1) begin
                r.load = 1'b1;
            end else if (k == n - 1) begin
                r.done  = 1'b1;
                r.err   = dz_op;
                r.count = dz_op ? 6'd0 : (m ? 6'(w - 1) : 6'(w / 2 - 1));
            end else if (in_run) begin
                r.count = 6'(s);
                r.sp    = 1'b1;
                if (!m) begin
                    d    = -2 * int'(b[2]) + int'(b[1]) + int'(b[0]);
                    r.add = d > 0;
                    r.sub = d < 0;
                    r.sm  = (d == 2) || (d == -2);
                end else begin
                    r.add = rr;
                    r.sub = !rr;
                    r.qb  = !rr;
                end
            end else begin
                r.count = 6'(w - 1);
                r.add   = rr;
            end
            tr.push_back(r);
            bv.push_back(b);
            rv.push_back(rr);
        end
        for (int k = 0; k < n; k++) begin
            if (abort_at < 0 || k <= abort_at) begin
                if (u == 0) q0.push_back(tr[k]);
                else        q1.push_back(tr[k]);
            end
        end
        for (int k = 0; k < n; k++) begin
            drive(u, (k == 0 || hold) ? 1'b1 : 1'($urandom),
                  (k == 0) ? m : 1'($urandom),
                  (k == 0) ? z : 1'($urandom), bv[k], rv[k]);
            if (k == abort_at) begin
                @(negedge clk);
                #2;
                last_cnt[0] = 0;
                last_cnt[1] = 0;
                rst_n = 1'b0;
                #1;
                check("async_reset_w32", idle_rec(0), act0);
                check("async_reset_w8", idle_rec(0), act1);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                drive(u, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
                return;
            end
            @(posedge clk);
            #1;
        end
        last_cnt[u] = int'(tr[n - 1].count);
        if (!hold) drive(u, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
    endtask

    initial begin
        bit m, z;
        last_cnt[0] = 0;
        last_cnt[1] = 0;
        drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        do_op(0, 1'b0, 1'b0, 1, 0, 1'b0, -1);
        idle(2);
        do_op(0, 1'b1, 1'b0, 2, 0, 1'b0, -1);
        idle(1);
        do_op(0, 1'b1, 1'b1, 0, 0, 1'b0, -1);
        do_op(0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
        do_op(0, 1'b0, 1'b0, 0, 0, 1'b0, 7);
        idle(2);
        do_op(0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
        do_op(1, 1'b0, 1'b0, 3, 0, 1'b0, -1);
        do_op(1, 1'b0, 1'b0, 3, 4, 1'b0, -1);
        idle(1);
        for (int i = 0; i < 3; i++) do_op(1, 1'b0, 1'b0, 0, 0, 1'b1, -1);
        drive(1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        idle(2);
        for (int i = 0; i < 10; i++) begin
            m = 1'($urandom);
            z = $urandom_range(0, 3) == 0;
            do_op($urandom_range(0, 1), m, z, 0, 0, 1'b0, -1);
            idle($urandom_range(0, 2));
        end
        do_op(1, 1'b1, 1'b0, 2, 0, 1'b0, -1);
        do_op(1, 1'b1, 1'b1, 0, 0, 1'b0, -1);
        idle(3);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: left %0d/%0d, expected 0/0",
                     q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_control.md
# muldiv_control

Parametrised sequencer for the iterative multiply/divide datapath. It replaces the fixed 32-step multiply controller with one FSM that drives radix-4 Booth multiplication (WIDTH/2 steps) or non-restoring division (WIDTH steps plus one correction step). It produces per-cycle datapath strobes and a start/ready/done handshake. It sits between the CPU's multdiv request logic and the shared product/remainder register, adder and multiplicand register.

## Interface
- WIDTH, 32, operand width. Must be even and ≥4; any other value is an elaboration error.
- COUNT_W, $clog2(WIDTH)+1, step-counter width. Derived; never overridden.

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = multiply, 1 = divide; sampled with start
- div_zero  in  1  divisor == 0 flag; sampled with start when mode=1
- booth_bits  in  3  current Booth window {b[2i+1], b[2i], b[2i-1]} from the product register
- rem_sign  in  1  sign bit of the current partial remainder
- load  out  1  load operands into the datapath registers
- add  out  1  adder adds the selected operand
- sub  out  1  adder subtracts the selected operand
- shift_multiplicand  out  1  select 2×multiplicand (Booth ±2M)
- shift_product  out  1  shift the product/remainder register (2 bits mult, 1 bit div)
- quot_bit  out  1  quotient bit shifted in (div only)
- busy  out  1  state ≠ IDLE
- ready  out  1  state == IDLE
- done  out  1  one-cycle pulse, result valid
- err  out  1  divide-by-zero; valid while done=1
- count  out  COUNT_W  current step index

## Operation
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE:
  - start=1 → LOAD; latch mode.
  - start=0 → stay.
  - start in any other state is ignored.
- LOAD:
  - load=1; count cleared to 0.
  - If latched mode=1 and div_zero was 1 at start → DONE with err=1.
  - Otherwise → RUN.
- RUN, multiply: Booth decode of booth_bits.
  - 000/111: no add/sub.
  - 001/010: add.
  - 011: add + shift_multiplicand.
  - 100: sub + shift_multiplicand.
  - 101/110: sub.
  - shift_product=1 every RUN cycle.
  - count increments each cycle; at count == WIDTH/2−1 → DONE.
- RUN, divide:
  - add = rem_sign, sub = !rem_sign, quot_bit = !rem_sign, shift_product=1.
  - At count == WIDTH−1 → FIX.
- FIX (divide only):
  - add = rem_sign (remainder correction), shift_product=0.
  - → DONE.
- DONE:
  - done=1; err held from LOAD.
  - → IDLE.
- All strobes are combinational from state and inputs; no strobe is asserted outside its listed state.
- count saturates at its terminal value; no wrap-around is ever visible.
- Reset, asynchronous and at any time including mid-operation: state=IDLE, count=0, err=0. All strobes, done and busy are 0; ready=1. Any operation in progress is discarded with no done pulse.

## Timing
- Edge E0 samples start in IDLE. LOAD occupies the cycle after E0; RUN begins after E1.
- Multiply: RUN is WIDTH/2 cycles. done is high in the cycle after edge E(WIDTH/2+1); ready returns one edge later.
- Divide: RUN is WIDTH cycles, then 1 FIX cycle. done is high after edge E(WIDTH+2); ready returns one edge later.
- Divide-by-zero: done and err are high after E1; ready returns after E2.
- start held high through DONE is ignored until IDLE. It is then re-sampled, so back-to-back operations have a 1-cycle ready gap.

## Structure
- Package muldiv_pkg: state enum, mode constants (MODE_MUL, MODE_DIV), Booth window constants.
- Sub-module booth4_decode: combinational; booth_bits → {add, sub, shift_multiplicand}. Instantiated once, gated by RUN and mode=0.
- One FSM process plus one count register in the top.

## Test plan
- WIDTH=32, mult, booth_bits forced 011 every cycle → add and shift_multiplicand high for 16 RUN cycles; done after E17; ready after E18.
- WIDTH=32, div, rem_sign alternating 0/1 from RUN start → sub/add/quot_bit alternate for 32 cycles. FIX asserts add iff rem_sign=1; done after E34.
- Divide with div_zero=1 → one load pulse; done=1 and err=1 after E1; no add/sub/shift; ready after E2.
- reset_n low at RUN count=5 → ready=1, count=0, all strobes 0 immediately. No done pulse. A new start is accepted normally.
- start held high continuously (WIDTH=8, mult) → operations repeat every 7 cycles. No start is accepted while busy.
- WIDTH=8, sweep all 8 booth_bits codes → strobe mapping matches the Booth decode list above; count terminates at 3.
